// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle controller: IR fields, flags,
// memory handshake and every datapath select/enable it drives.
interface multicycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             RegDst;
    logic             Link;
    logic             reg_write;
    logic [1:0]       mem_to_reg;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, RegDst, Link, reg_write,
               mem_to_reg, illegal, state, retired
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, RegDst, Link, reg_write,
               mem_to_reg, illegal, state, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences ALU, memory port and write-back selects
// per instruction class, and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        K_ILL, K_ALU, K_JR, K_LW, K_SW, K_BEQ, K_ADDI, K_ORI, K_J, K_JAL
    } kind_e;

    localparam int unsigned OP_W = 6;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [OP_W-1:0]   funct_q, funct_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    kind_e             kind_in, kind_q;

    logic       mem_req_c, mem_write_c, iord_c, ir_write_c, pc_write_c;
    logic [1:0] pc_src_c, alu_src_b_c, alu_op_c, mem_to_reg_c;
    logic       alu_src_a_c, reg_dst_c, link_c, reg_write_c, illegal_c;

    // Instruction class from opcode/funct; anything unlisted is illegal.
    function automatic kind_e decode(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
        kind_e k;
        k = K_ILL;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: k = K_ALU;
                    6'h08:                             k = K_JR;
                    default:                           k = K_ILL;
                endcase
            end
            6'h23:   k = K_LW;
            6'h2B:   k = K_SW;
            6'h04:   k = K_BEQ;
            6'h08:   k = K_ADDI;
            6'h0D:   k = K_ORI;
            6'h02:   k = K_J;
            6'h03:   k = K_JAL;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    // The IR is written at the end of FETCH, so DECODE reads it straight off the bus.
    assign kind_in = decode(bus.opcode, bus.funct);
    assign kind_q  = decode(op_q, funct_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            funct_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        funct_d      = funct_q;
        retired_d    = retired_q;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        iord_c       = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 2'd0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'd0;
        alu_op_c     = 2'd0;
        reg_dst_c    = 1'b0;
        link_c       = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 2'd0;
        illegal_c    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'd1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                op_d        = bus.opcode;
                funct_d     = bus.funct;
                alu_src_b_c = 2'd3;
                if (kind_in == K_ILL) begin
                    illegal_c = 1'b1;
                    state_d   = FETCH;
                end else begin
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                case (kind_q)
                    K_ALU: begin
                        alu_src_a_c = 1'b1;
                        alu_op_c    = 2'd2;
                        state_d     = WB;
                    end
                    K_LW, K_SW, K_ADDI: begin
                        alu_src_a_c = 1'b1;
                        alu_src_b_c = 2'd2;
                        state_d     = (kind_q == K_ADDI) ? WB : MEM;
                    end
                    K_ORI: begin
                        alu_src_a_c = 1'b1;
                        alu_src_b_c = 2'd2;
                        alu_op_c    = 2'd3;
                        state_d     = WB;
                    end
                    K_BEQ: begin
                        alu_src_a_c = 1'b1;
                        alu_op_c    = 2'd1;
                        pc_src_c    = 2'd1;
                        pc_write_c  = bus.zero;
                        state_d     = FETCH;
                    end
                    K_J, K_JAL: begin
                        pc_src_c   = 2'd2;
                        pc_write_c = 1'b1;
                        if (kind_q == K_JAL) begin
                            reg_write_c  = 1'b1;
                            link_c       = 1'b1;
                            mem_to_reg_c = 2'd2;
                        end
                        state_d = FETCH;
                    end
                    K_JR: begin
                        pc_src_c   = 2'd3;
                        pc_write_c = 1'b1;
                        state_d    = FETCH;
                    end
                    default: state_d = FETCH;
                endcase
            end
            MEM: begin
                mem_req_c   = 1'b1;
                iord_c      = 1'b1;
                mem_write_c = (kind_q == K_SW);
                if (bus.mem_ready) begin
                    state_d = (kind_q == K_LW) ? WB : FETCH;
                end
            end
            WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = (kind_q == K_ALU);
                mem_to_reg_c = (kind_q == K_LW) ? 2'd1 : 2'd0;
                state_d      = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // Completion of a legal instruction: any return to FETCH past DECODE.
        if (state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign bus.mem_req    = mem_req_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.iord       = iord_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.RegDst     = reg_dst_c;
    assign bus.Link       = link_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.illegal    = illegal_c;
    assign bus.state      = 3'(state_q);
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction trace model pushes
// expected per-cycle outputs; a monitor compares them against the DUT.
module tb_multicycle_ctrl;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();
    multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [2:0]       st;
        logic             mem_req;
        logic             mem_write;
        logic             iord;
        logic             ir_write;
        logic             pc_write;
        logic [1:0]       pc_src;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [1:0]       alu_op;
        logic             reg_dst;
        logic             link;
        logic             reg_write;
        logic [1:0]       mem_to_reg;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } obs_t;

    obs_t             exp_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] m_ret;
    logic [11:0]      legal_tab [13] = '{
        {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25},
        {6'h00, 6'h2A}, {6'h00, 6'h08}, {6'h23, 6'h00}, {6'h2B, 6'h00},
        {6'h04, 6'h00}, {6'h08, 6'h00}, {6'h0D, 6'h00}, {6'h02, 6'h00},
        {6'h03, 6'h00}};

    function automatic bit is_legal(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
        return op inside {6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h02, 6'h03};
    endfunction

    function automatic obs_t blank(logic [2:0] st);
        obs_t o;
        o         = '0;
        o.st      = st;
        o.retired = m_ret;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st         = bus.state;
        o.mem_req    = bus.mem_req;
        o.mem_write  = bus.mem_write;
        o.iord       = bus.iord;
        o.ir_write   = bus.ir_write;
        o.pc_write   = bus.pc_write;
        o.pc_src     = bus.pc_src;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_op     = bus.alu_op;
        o.reg_dst    = bus.RegDst;
        o.link       = bus.Link;
        o.reg_write  = bus.reg_write;
        o.mem_to_reg = bus.mem_to_reg;
        o.illegal    = bus.illegal;
        o.retired    = bus.retired;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle: apply mem_ready, queue the expected outputs, advance.
    task automatic step(input obs_t o, input logic mr);
        bus.mem_ready = mr;
        exp_q.push_back(o);
        @(negedge clk);
    endtask

    function automatic obs_t fetch_obs(input logic done);
        obs_t o;
        o           = blank(3'd1);
        o.mem_req   = 1'b1;
        o.alu_src_b = 2'd1;
        o.ir_write  = done;
        o.pc_write  = done;
        return o;
    endfunction

    // Expands one instruction into its expected cycle-by-cycle trace.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        obs_t o;
        bit   lg, to_mem, to_wb;
        lg     = is_legal(op, fn);
        to_mem = 1'b0;
        to_wb  = 1'b0;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        for (int i = 0; i < fw; i++) step(fetch_obs(1'b0), 1'b0);
        step(fetch_obs(1'b1), 1'b1);
        o           = blank(3'd2);
        o.alu_src_b = 2'd3;
        o.illegal   = !lg;
        step(o, 1'($urandom_range(0, 1)));
        if (!lg) return;
        o = blank(3'd3);
        case (op)
            6'h00: begin
                if (fn == 6'h08) begin
                    o.pc_src = 2'd3; o.pc_write = 1'b1;
                end else begin
                    o.alu_src_a = 1'b1; o.alu_op = 2'd2; to_wb = 1'b1;
                end
            end
            6'h23, 6'h2B: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; to_mem = 1'b1; end
            6'h08: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; to_wb = 1'b1; end
            6'h0D: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 2'd3; to_wb = 1'b1; end
            6'h04: begin o.alu_src_a = 1'b1; o.alu_op = 2'd1; o.pc_src = 2'd1; o.pc_write = z; end
            6'h02: begin o.pc_src = 2'd2; o.pc_write = 1'b1; end
            default: begin
                o.pc_src = 2'd2; o.pc_write = 1'b1; o.reg_write = 1'b1;
                o.link = 1'b1; o.mem_to_reg = 2'd2;
            end
        endcase
        step(o, 1'($urandom_range(0, 1)));
        if (to_mem) begin
            o           = blank(3'd4);
            o.mem_req   = 1'b1;
            o.iord      = 1'b1;
            o.mem_write = (op == 6'h2B);
            for (int i = 0; i < mw; i++) step(o, 1'b0);
            step(o, 1'b1);
            to_wb = (op == 6'h23);
        end
        if (to_wb) begin
            o            = blank(3'd5);
            o.reg_write  = 1'b1;
            o.reg_dst    = (op == 6'h00);
            o.mem_to_reg = (op == 6'h23) ? 2'd1 : 2'd0;
            step(o, 1'($urandom_range(0, 1)));
        end
        m_ret = CNT_W'(m_ret + 1);
    endtask

    // Monitor: compare one queued expectation per cycle, mid low phase.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                a = sample();
                e = exp_q.pop_front();
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL cycle_trace t=%0t state=%0d: got %h expected %h",
                             $time, e.st, a, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op, fn;
        obs_t       o;
        int         idx;
        rst_n         = 1'b0;
        m_ret         = '0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        step(blank(3'd0), 1'b1);
        step(blank(3'd0), 1'b1);
        rst_n = 1'b1;
        step(blank(3'd0), 1'b1);

        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        run_instr(6'h23, 6'h11, 1'b0, 0, 2);
        run_instr(6'h04, 6'h00, 1'b1, 0, 0);
        run_instr(6'h04, 6'h00, 1'b0, 0, 0);
        run_instr(6'h03, 6'h05, 1'b0, 0, 0);
        run_instr(6'h00, 6'h08, 1'b0, 0, 0);
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
        run_instr(6'h00, 6'h3F, 1'b0, 1, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                idx = int'($urandom_range(0, 12));
                op  = legal_tab[idx][11:6];
                fn  = (op == 6'h00) ? legal_tab[idx][5:0] : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr(op, fn, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Async reset while a load is stalled in MEM.
        bus.opcode = 6'h23;
        bus.funct  = 6'h00;
        step(fetch_obs(1'b1), 1'b1);
        o = blank(3'd2); o.alu_src_b = 2'd3;
        step(o, 1'b0);
        o = blank(3'd3); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2;
        step(o, 1'b0);
        o = blank(3'd4); o.mem_req = 1'b1; o.iord = 1'b1;
        step(o, 1'b0);
        #2;
        chk("mem_req_before_reset", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mem_req_in_reset", 32'(bus.mem_req), 32'd0);
        chk("state_in_reset", 32'(bus.state), 32'd0);
        chk("retired_in_reset", 32'(bus.retired), 32'd0);
        m_ret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(blank(3'd0), 1'b1);
        step(fetch_obs(1'b0), 1'b0);
        bus.opcode = 6'h02;
        step(fetch_obs(1'b1), 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the shared datapath: one ALU, one memory port, and the 2/3/4-to-1 32-bit selectors plus the RegDst/Link write-address selectors. It decodes the latched opcode/funct and drives every selector and write-enable cycle by cycle. Memory accesses use a req/ready handshake. It also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
mem_write  out  1  1=store, 0=read (valid with mem_req)
iord  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR/latch instruction
pc_write  out  1  PC load enable
pc_src  out  2  4:1 sel: 0=ALU, 1=ALUOut, 2=jump target, 3=rs
alu_src_a  out  1  2:1 sel: 0=PC, 1=rs
alu_src_b  out  2  4:1 sel: 0=rt, 1=const 4, 2=sign-ext imm, 3=imm<<2
alu_op  out  2  0=add, 1=sub, 2=funct-decoded, 3=or
RegDst  out  1  0=rt, 1=rd
Link  out  1  1 forces write address 31
reg_write  out  1  register file write enable
mem_to_reg  out  2  3:1 sel: 0=ALUOut, 1=MDR, 2=PC
illegal  out  1  one-cycle pulse on undecodable instruction
state  out  3  current state (debug)
retired  out  CNT_W  instructions completed

Behaviour:
- States (encoding): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Reset (async, rst_n=0): state=IDLE, retired=0, latched op/funct=0. All outputs are 0 during reset and in IDLE. The reset value of every output is 0.
- Reset mid-operation: state is forced to IDLE immediately. A pending mem_req drops in the same cycle.
- IDLE: next state is FETCH unconditionally (one cycle).
- FETCH:
  - mem_req=1, mem_write=0, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0.
  - The state holds while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, pc_src=0, and the state moves to DECODE.
- DECODE:
  - Latch opcode/funct internally.
  - alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
  - Next state is EXEC for a legal instruction.
  - For any other opcode, or for op=0 with an undefined funct: illegal=1 for this cycle, next state FETCH, retired unchanged.
- Legal instructions:
  - R-type (op 0x00): funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - I-type and jumps: lw 0x23, sw 0x2B, beq 0x04, addi 0x08, ori 0x0D, j 0x02, jal 0x03.
- EXEC, per instruction:
  - R-type (non-jr): alu_src_a=1, alu_src_b=0, alu_op=2. Next state WB.
  - lw/sw/addi: alu_src_a=1, alu_src_b=2, alu_op=0. lw/sw go to MEM; addi goes to WB.
  - ori: alu_src_a=1, alu_src_b=2, alu_op=3. Next state WB.
  - beq: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, pc_write=zero. Next state FETCH.
  - j: pc_src=2, pc_write=1. Next state FETCH.
  - jal: pc_src=2, pc_write=1, reg_write=1, Link=1, mem_to_reg=2. Next state FETCH.
  - jr: pc_src=3, pc_write=1. Next state FETCH.
- MEM:
  - mem_req=1, iord=1, mem_write=1 for sw and 0 for lw.
  - The state holds while mem_ready=0.
  - On mem_ready: lw goes to WB; sw goes to FETCH.
- WB: reg_write=1.
  - R-type: RegDst=1, mem_to_reg=0.
  - addi/ori: RegDst=0, mem_to_reg=0.
  - lw: RegDst=0, mem_to_reg=1.
  - Next state FETCH.
- Link=1 only for jal in EXEC; Link=0 everywhere else.
- retired increments by 1 on every transition into FETCH from EXEC, MEM or WB (completion of a legal instruction). It wraps modulo 2^CNT_W.
- Cycle counts with zero wait states:
  - j/jal/jr/beq: 3 cycles.
  - R-type/addi/ori/sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle with mem_ready=0 in FETCH or MEM adds one cycle.
- All outputs are combinational functions of state and the latched op/funct. Exception: FETCH also uses mem_ready, and beq in EXEC also uses zero. No other input paths exist.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset: rst_n=0 asynchronously in MEM with mem_req=1 -> mem_req=0 immediately, state=0, retired=0. After release: IDLE for 1 cycle, then FETCH with mem_req=1.
- R-type add (op=0, funct=0x20), mem_ready always 1 -> states 1,2,3,5,1. In WB: reg_write=1, RegDst=1, mem_to_reg=0. retired 0->1.
- lw with mem_ready low 2 cycles in MEM -> MEM lasts 3 cycles with iord=1, mem_write=0. WB has mem_to_reg=1, RegDst=0. Total 7 cycles.
- beq with zero=1, then zero=0 -> pc_write=1, pc_src=1 in EXEC for the first; pc_write=0 for the second. Each is 3 cycles.
- jal -> EXEC: Link=1, reg_write=1, mem_to_reg=2, pc_src=2, pc_write=1. jr (funct 0x08) -> pc_src=3, reg_write=0.
- Illegal opcode 0x3F -> illegal pulse in DECODE, next state FETCH, retired unchanged. Also drive retired to 2^CNT_W-1 and complete one instruction -> retired wraps to 0.
